instr_fetch: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Reads the instruction at the current PC from instruction ROM over a req/ack handshake and holds it in an instruction register.
- Hands the instruction to the decoder over a valid/ready handshake.
- Drives the PC's write-enable, add-offset and address inputs: holds the PC during wait states, and resolves JMP/BR instructions so the PC jumps or adds an offset.

---
 rtl/jac_isa_pkg.sv | 21 ++
 rtl/branch_resolve.sv | 65 ++++++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jac_isa_pkg.sv
// Shared ISA definitions for the fetch slice: instruction field positions,
// the opcodes that redirect the PC, and the fetch state encoding.
package jac_isa_pkg;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;
    localparam int IMM_WIDTH = IMM_MSB - IMM_LSB + 1;

    localparam logic [3:0] OPC_JMP = 4'hE;
    localparam logic [3:0] OPC_BR  = 4'hF;
    localparam logic [3:0] OPC_BRZ = 4'hD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_resolve.sv
// Combinational PC-control decode: HOLD during wait states, JMP/BR at handoff.
// INSTR_FETCH_COND_BRANCH_EN adds BRZ (branch when zero_flag is set).
module branch_resolve
    import jac_isa_pkg::*;
#(
    parameter int PC_WIDTH  = 8,
    parameter int OPC_WIDTH = 4
) (
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 zero_flag,
    input  logic                 handoff,
    input  logic                 hold,
    output logic                 pc_wr_en,
    output logic                 pc_add_offset,
    output logic [PC_WIDTH-1:0]  pc_counteradress
);

    logic [PC_WIDTH-1:0] jmp_target;
    logic [PC_WIDTH-1:0] br_offset;

    // Absolute targets are unsigned; branch offsets are two's-complement.
    assign jmp_target = PC_WIDTH'(imm);
    assign br_offset  = PC_WIDTH'($signed(imm));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_wr_en         = 1'b0;
        pc_add_offset    = 1'b0;
        pc_counteradress = '0;
        if (handoff) begin
            case (opcode)
                OPC_JMP: begin
                    pc_wr_en         = 1'b1;
                    pc_counteradress = jmp_target;
                end
                OPC_BR: begin
                    pc_wr_en         = 1'b1;
                    pc_add_offset    = 1'b1;
                    pc_counteradress = br_offset;
                end
`ifdef INSTR_FETCH_COND_BRANCH_EN
                OPC_BRZ: begin
                    if (zero_flag) begin
                        pc_wr_en         = 1'b1;
                        pc_add_offset    = 1'b1;
                        pc_counteradress = br_offset;
                    end
                end
`endif
                default: ;
            endcase
        end else if (hold) begin
            pc_wr_en         = 1'b1;
            pc_counteradress = pc;
        end
    end

`ifndef INSTR_FETCH_COND_BRANCH_EN
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads ROM at the current PC, holds the word for the decoder and
// steers the PC (hold / jump / branch). Optional BRZ: INSTR_FETCH_COND_BRANCH_EN.
module instr_fetch
    import jac_isa_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int OPC_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   pc_wr_en,
    output logic                   pc_add_offset,
    output logic [PC_WIDTH-1:0]    pc_counteradress,
    output logic                   rom_req,
    output logic [PC_WIDTH-1:0]    rom_addr,
    input  logic                   rom_ack,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   zero_flag
);

    fetch_state_e state;
    logic         handoff;
    logic         hold;

    // The PC is held for the whole FETCH, so the address stays stable under rom_req.
    assign rom_addr = pc;
    assign handoff  = (state == ISSUE) && instr_valid && instr_ready;
    assign hold     = (state == FETCH) || ((state == ISSUE) && !instr_ready);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (res) begin
            state       <= IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            rom_req     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    rom_req <= 1'b1;
                end
                FETCH: begin
                    if (rom_ack) begin
                        instr       <= rom_data;
                        instr_valid <= 1'b1;
                        rom_req     <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        rom_req     <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    rom_req     <= 1'b0;
                end
            endcase
        end
    end

    branch_resolve #(
        .PC_WIDTH (PC_WIDTH),
        .OPC_WIDTH(OPC_WIDTH)
    ) u_branch_resolve (
        .opcode          (instr[OPC_MSB:OPC_LSB]),
        .imm             (instr[IMM_MSB:IMM_LSB]),
        .pc              (pc),
        .zero_flag       (zero_flag),
        .handoff         (handoff),
        .hold            (hold),
        .pc_wr_en        (pc_wr_en),
        .pc_add_offset   (pc_add_offset),
        .pc_counteradress(pc_counteradress)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a PC model, a ROM responder with settable ack
// delay, hand-written multi-cycle sequences and a table of single-instruction vectors.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [7:0]  pc_q = 8'hFF;
    logic        pc_wr_en;
    logic        pc_add_offset;
    logic [7:0]  pc_counteradress;
    logic        rom_req;
    logic [7:0]  rom_addr;
    logic        rom_ack = 1'b0;
    logic [15:0] rom_data = 16'h0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        zero_flag = 1'b0;

    logic [15:0] rom [256];
    int          ack_delay = 0;
    int          rom_wait = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        zf;
        logic        exp_wr;
        logic        exp_add;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vecs [10];

    instr_fetch #(
        .PC_WIDTH   (8),
        .INSTR_WIDTH(16),
        .OPC_WIDTH  (4)
    ) dut (
        .clk             (clk),
        .res             (res),
        .pc              (pc_q),
        .pc_wr_en        (pc_wr_en),
        .pc_add_offset   (pc_add_offset),
        .pc_counteradress(pc_counteradress),
        .rom_req         (rom_req),
        .rom_addr        (rom_addr),
        .rom_ack         (rom_ack),
        .rom_data        (rom_data),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .zero_flag       (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: latch PC controls, clock the PC model, then answer the ROM.
    task automatic step();
        logic       wr;
        logic       add;
        logic [7:0] ca;
        logic       r;
        #1;
        wr  = pc_wr_en;
        add = pc_add_offset;
        ca  = pc_counteradress;
        r   = res;
        @(posedge clk);
        #1;
        if (r)        pc_q = 8'hFF;
        else if (wr)  pc_q = add ? (pc_q + ca + 8'd1) : ca;
        else          pc_q = pc_q + 8'd1;
        #1;
        if (rom_req) begin
            if (rom_wait >= ack_delay) begin
                rom_ack  = 1'b1;
                rom_data = rom[rom_addr];
            end else begin
                rom_ack  = 1'b0;
                rom_data = 16'h0;
            end
            rom_wait++;
        end else begin
            rom_ack  = 1'b0;
            rom_data = 16'h0;
            rom_wait = 0;
        end
        #1;
    endtask

    // Reset, then preload the PC so the IDLE increment lands on addr in FETCH.
    task automatic start_at(input logic [7:0] addr);
        res = 1'b1;
        step();
        res  = 1'b0;
        pc_q = addr - 8'd1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[1] = '{8'h10, 16'hE042, 1'b0, 1'b1, 1'b0, 8'h42};
        vecs[2] = '{8'h20, 16'hF0FD, 1'b0, 1'b1, 1'b1, 8'h1E};
        vecs[3] = '{8'hFF, 16'h7777, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{8'h40, 16'hF0FF, 1'b0, 1'b1, 1'b1, 8'h40};
`ifdef INSTR_FETCH_COND_BRANCH_EN
        vecs[5] = '{8'h30, 16'hD005, 1'b1, 1'b1, 1'b1, 8'h36};
`else
        vecs[5] = '{8'h30, 16'hD005, 1'b1, 1'b0, 1'b0, 8'h31};
`endif
        vecs[6] = '{8'h30, 16'hD005, 1'b0, 1'b0, 1'b0, 8'h31};
        vecs[7] = '{8'h50, 16'hE0FF, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[8] = '{8'h60, 16'hC0AB, 1'b1, 1'b0, 1'b0, 8'h61};
        vecs[9] = '{8'h70, 16'hF010, 1'b0, 1'b1, 1'b1, 8'h81};

        for (int i = 0; i < 256; i++) rom[i] = 16'(i);

        // Reset state, then first fetch with immediate ack and ready tied high.
        rom[8'h00]  = 16'h1234;
        ack_delay   = 0;
        instr_ready = 1'b1;
        res         = 1'b1;
        step();
        step();
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_wr_en", 32'(pc_wr_en), 32'd0);
        check("rst_add", 32'(pc_add_offset), 32'd0);
        check("rst_caddr", 32'(pc_counteradress), 32'd0);
        res = 1'b0;
        #1;
        check("idle_rom_req", 32'(rom_req), 32'd0);
        check("idle_wr_en", 32'(pc_wr_en), 32'd0);
        step();
        check("f0_pc", 32'(pc_q), 32'h00);
        check("f0_rom_addr", 32'(rom_addr), 32'h00);
        check("f0_rom_req", 32'(rom_req), 32'd1);
        check("f0_hold_despite_ready", 32'(pc_wr_en), 32'd1);
        check("f0_valid", 32'(instr_valid), 32'd0);
        step();
        check("i0_instr", 32'(instr), 32'h1234);
        check("i0_valid", 32'(instr_valid), 32'd1);
        check("i0_rom_req", 32'(rom_req), 32'd0);
        check("i0_wr_en", 32'(pc_wr_en), 32'd0);
        step();
        check("i0_pc_next", 32'(pc_q), 32'h01);
        check("i0_valid_drop", 32'(instr_valid), 32'd0);
        check("i0_refetch_req", 32'(rom_req), 32'd1);

        // ROM ack delayed 3 cycles at pc=0x05; stray ack in ISSUE is ignored.
        rom[8'h05]  = 16'h3A5C;
        ack_delay   = 3;
        instr_ready = 1'b0;
        start_at(8'h05);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wait_rom_req", 32'(rom_req), 32'd1);
            check("wait_rom_addr", 32'(rom_addr), 32'h05);
            check("wait_pc", 32'(pc_q), 32'h05);
            check("wait_valid", 32'(instr_valid), 32'd0);
            if (i < 3) step();
        end
        step();
        check("wait_instr", 32'(instr), 32'h3A5C);
        check("wait_instr_valid", 32'(instr_valid), 32'd1);
        rom_ack  = 1'b1;
        rom_data = 16'hBEEF;
        step();
        check("stray_ack_instr", 32'(instr), 32'h3A5C);
        check("stray_ack_valid", 32'(instr_valid), 32'd1);
        check("stray_ack_pc", 32'(pc_q), 32'h05);
        instr_ready = 1'b1;
        step();
        check("wait_pc_next", 32'(pc_q), 32'h06);

        // JMP with decoder back-pressure for 4 cycles.
        rom[8'h10]  = 16'hE042;
        ack_delay   = 0;
        instr_ready = 1'b0;
        start_at(8'h10);
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_pc", 32'(pc_q), 32'h10);
            check("bp_wr_en", 32'(pc_wr_en), 32'd1);
            check("bp_caddr", 32'(pc_counteradress), 32'h10);
            check("bp_instr", 32'(instr), 32'hE042);
            step();
        end
        instr_ready = 1'b1;
        ack_delay   = 20;
        #1;
        check("jmp_wr_en", 32'(pc_wr_en), 32'd1);
        check("jmp_add", 32'(pc_add_offset), 32'd0);
        check("jmp_caddr", 32'(pc_counteradress), 32'h42);
        step();
        check("jmp_pc", 32'(pc_q), 32'h42);
        check("jmp_valid_drop", 32'(instr_valid), 32'd0);
        check("jmp_rom_req", 32'(rom_req), 32'd1);

        // Reset pulse while a ROM request is outstanding.
        res = 1'b1;
        step();
        res = 1'b0;
        #1;
        check("midrst_rom_req", 32'(rom_req), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", 32'(instr), 32'd0);
        check("midrst_wr_en", 32'(pc_wr_en), 32'd0);
        check("midrst_caddr", 32'(pc_counteradress), 32'd0);
        step();
        check("midrst_refetch_req", 32'(rom_req), 32'd1);
        check("midrst_refetch_pc", 32'(pc_q), 32'h00);

        // Single-instruction vectors: immediate ack, ready high.
        ack_delay   = 0;
        instr_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            rom[vecs[v].addr] = vecs[v].data;
            zero_flag         = vecs[v].zf;
            start_at(vecs[v].addr);
            #1;
            check("vec_rom_addr", 32'(rom_addr), 32'(vecs[v].addr));
            check("vec_fetch_hold", 32'(pc_wr_en), 32'd1);
            step();
            check("vec_instr", 32'(instr), 32'(vecs[v].data));
            check("vec_valid", 32'(instr_valid), 32'd1);
            check("vec_wr_en", 32'(pc_wr_en), 32'(vecs[v].exp_wr));
            check("vec_add", 32'(pc_add_offset), 32'(vecs[v].exp_add));
            step();
            check("vec_next_pc", 32'(pc_q), 32'(vecs[v].exp_pc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
